// File: rtl/apu_int_responder.sv
// rtl/apu_int_responder.sv - integer stand-in for the shared APU
// Executes a small integer op set and returns results in issue order after a fixed per-class latency.
module apu_int_responder #(
  parameter int WOP        = 6,
  parameter int NARGS      = 3,
  parameter int NDSFLAGS   = 15,
  parameter int NUSFLAGS   = 5,
  parameter int LAT_ADDSUB = 1,
  parameter int LAT_MULT   = 1,
  parameter int LAT_CAST   = 1,
  parameter int LAT_MAC    = 2,
  parameter int LAT_DIV    = 4,
  parameter int LAT_SQRT   = 5
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        apu_req_i,
  output logic                        apu_gnt_o,
  input  logic [WOP-1:0]              apu_op_i,
  input  logic [NARGS-1:0][31:0]      apu_operands_i,
  input  logic [NDSFLAGS-1:0]         apu_flags_i,
  output logic                        apu_rvalid_o,
  output logic [31:0]                 apu_result_o,
  output logic [NUSFLAGS-1:0]         apu_flags_o,
  output logic                        busy_o
);

  function automatic int max2(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  localparam int DEPTH = max2(max2(max2(LAT_ADDSUB, LAT_MULT), max2(LAT_CAST, LAT_MAC)),
                              max2(LAT_DIV, LAT_SQRT));

  // Restoring digit-by-digit square root, unrolled for 32-bit input.
  function automatic logic [15:0] isqrt(input logic [31:0] x);
    logic [31:0] num, res, bitv;
    num  = x;
    res  = '0;
    bitv = 32'h4000_0000;
    for (int k = 0; k < 16; k++) begin
      if (num >= res + bitv) begin
        num = num - (res + bitv);
        res = (res >> 1) + bitv;
      end else begin
        res = res >> 1;
      end
      bitv = bitv >> 2;
    end
    return res[15:0];
  endfunction

  logic [DEPTH-1:0]                valid_q, valid_d;
  logic [DEPTH-1:0][31:0]          result_q, result_d;
  logic [DEPTH-1:0][NUSFLAGS-1:0]  flags_q, flags_d;

  logic [31:0]         op_a, op_b, op_c, sum, diff, mac;
  logic [63:0]         prod;
  logic [31:0]         res_c;
  logic [NUSFLAGS-1:0] flg_c;
  int                  op_idx, lat_c;
  logic                blocked, accept;
  logic                unused_flags;

  assign op_a   = apu_operands_i[0];
  assign op_b   = apu_operands_i[1];
  assign op_c   = apu_operands_i[2];
  assign sum    = op_a + op_b;
  assign diff   = op_a - op_b;
  assign prod   = 64'(op_a) * 64'(op_b);
  assign mac    = prod[31:0] + op_c;
  assign op_idx = int'(apu_op_i);
  assign unused_flags = ^apu_flags_i;

  // Flag bit positions: NV=4, DZ=3, OF=2; UF/NX stay 0.
  always_comb begin
    res_c = '0;
    flg_c = '0;
    lat_c = 1;
    case (op_idx)
      0: begin
        res_c    = sum;
        flg_c[2] = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
        lat_c    = LAT_ADDSUB;
      end
      1: begin
        res_c    = diff;
        flg_c[2] = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
        lat_c    = LAT_ADDSUB;
      end
      2: begin
        res_c    = prod[31:0];
        flg_c[2] = |prod[63:32];
        lat_c    = LAT_MULT;
      end
      3: begin
        res_c = mac;
        lat_c = LAT_MAC;
      end
      4: begin
        res_c    = op_a[31] ? (32'd0 - op_a) : op_a;
        flg_c[2] = (op_a == 32'h8000_0000);
        lat_c    = LAT_CAST;
      end
      5: begin
        res_c    = (op_b == 32'd0) ? 32'hFFFF_FFFF : (op_a / op_b);
        flg_c[3] = (op_b == 32'd0);
        lat_c    = LAT_DIV;
      end
      6: begin
        res_c = {16'd0, isqrt(op_a)};
        lat_c = LAT_SQRT;
      end
      default: begin
        flg_c[4] = 1'b1;
      end
    endcase
  end

  // Anything in flight at or beyond the new op's slot would collide or finish after it.
  always_comb begin
    blocked = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (i >= lat_c)) blocked = 1'b1;
    end
  end

  assign apu_gnt_o = !rst_i && !blocked;
  assign accept    = apu_req_i && apu_gnt_o;

  always_comb begin
    valid_d  = '0;
    result_d = '0;
    flags_d  = '0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      valid_d[i]  = valid_q[i+1];
      result_d[i] = result_q[i+1];
      flags_d[i]  = flags_q[i+1];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (accept && (i == lat_c - 1)) begin
        valid_d[i]  = 1'b1;
        result_d[i] = res_c;
        flags_d[i]  = flg_c;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign apu_rvalid_o = valid_q[0];
  assign apu_result_o = valid_q[0] ? result_q[0] : 32'd0;
  assign apu_flags_o  = valid_q[0] ? flags_q[0] : '0;
  assign busy_o       = |valid_q;

endmodule
